// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select through addresses 0..3, holding each SETTLE clocks, and packs the samples into a 4-bit word.
// Latency: valid rises 4*SETTLE clocks after start is taken; data/valid are held until a valid&ready handshake.
// MUX_SCAN_AUTO_EN: when defined, a handshake starts the next scan straight away instead of returning to IDLE.
module mux_scan_sequencer #(
    parameter int SETTLE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       address0,
    output logic       address1,
    input  logic       muxout,
    output logic [3:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0] SETTLE_LAST = 2'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [1:0] settle_q, settle_d;
    logic [3:0] cap_q, cap_d;
    logic [3:0] data_q, data_d;
    logic       valid_q, valid_d;
    logic       window_end;
    logic       handshake;

    assign window_end = (settle_q == SETTLE_LAST);
    assign handshake  = valid_q && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_SCAN;
            S_SCAN: if (window_end && addr_q == 2'd3) state_d = S_DONE;
            S_DONE: begin
                if (handshake) begin
`ifdef MUX_SCAN_AUTO_EN
                    state_d = S_SCAN;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= 2'd0;
            settle_q <= 2'd0;
            cap_q    <= 4'd0;
            data_q   <= 4'd0;
            valid_q  <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            settle_q <= settle_d;
            cap_q    <= cap_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        addr_d   = addr_q;
        settle_d = settle_q;
        cap_d    = cap_q;
        data_d   = data_q;
        valid_d  = valid_q;
        case (state_q)
            S_IDLE: begin
                addr_d   = 2'd0;
                settle_d = 2'd0;
            end
            S_SCAN: begin
                if (window_end) begin
                    // addr 3 + 1 wraps to 0 exactly as the word is published
                    cap_d[addr_q] = muxout;
                    addr_d        = addr_q + 2'd1;
                    settle_d      = 2'd0;
                    if (addr_q == 2'd3) begin
                        data_d  = cap_d;
                        valid_d = 1'b1;
                    end
                end else begin
                    settle_d = settle_q + 2'd1;
                end
            end
            S_DONE: begin
                if (handshake) begin
                    valid_d  = 1'b0;
                    addr_d   = 2'd0;
                    settle_d = 2'd0;
                end
            end
            default: begin
                addr_d   = 2'd0;
                settle_d = 2'd0;
                valid_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        address0 = addr_q[0];
        address1 = addr_q[1];
        data     = data_q;
        valid    = valid_q;
        busy     = (state_q != S_IDLE);
    end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Drives a SETTLE=1 and a SETTLE=3 sequencer against a behavioural 4:1 mux and a word-level expectation model.
module tb_mux_scan_sequencer;

`ifdef MUX_SCAN_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] start;
    logic [1:0] ready;
    logic [3:0] in_bits [2];
    logic [3:0] last_word [2];
    wire  [1:0] a0_w, a1_w, valid_w, busy_w, muxout_w;
    wire  [7:0] data_w;

    int n_assert = 0;
    int n_fail   = 0;

    // Behavioural multiplexer: selects input {address1,address0}
    assign muxout_w[0] = in_bits[0][{a1_w[0], a0_w[0]}];
    assign muxout_w[1] = in_bits[1][{a1_w[1], a0_w[1]}];

    mux_scan_sequencer #(.SETTLE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start[0]),
        .address0(a0_w[0]), .address1(a1_w[0]), .muxout(muxout_w[0]),
        .data(data_w[3:0]), .valid(valid_w[0]), .ready(ready[0]), .busy(busy_w[0])
    );

    mux_scan_sequencer #(.SETTLE(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start[1]),
        .address0(a0_w[1]), .address1(a1_w[1]), .muxout(muxout_w[1]),
        .data(data_w[7:4]), .valid(valid_w[1]), .ready(ready[1]), .busy(busy_w[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] addr_of(input int k);
        return {6'd0, a1_w[k], a0_w[k]};
    endfunction

    function automatic logic [7:0] data_of(input int k);
        return {4'd0, data_w[k*4 +: 4]};
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_quiet(input int k, input string tag);
        check({tag, ":addr"},  addr_of(k), 8'd0);
        check({tag, ":valid"}, {7'd0, valid_w[k]}, 8'd0);
        check({tag, ":busy"},  {7'd0, busy_w[k]}, 8'd0);
        check({tag, ":data"},  data_of(k), {4'd0, last_word[k]});
    endtask

    // One scan on instance k (settle s); the expected word is simply the mux inputs in address order.
    task automatic run_scan(input int k, input int s, input logic [3:0] inb,
                            input int hold, input bit do_start, input string tag);
        in_bits[k] = inb;
        if (do_start) begin
            start[k] = 1'b1;
            step();
        end
        for (int c = 0; c < 4 * s; c++) begin
            check({tag, ":scan_addr"},  addr_of(k), 8'(c / s));
            check({tag, ":scan_valid"}, {7'd0, valid_w[k]}, 8'd0);
            check({tag, ":scan_busy"},  {7'd0, busy_w[k]}, 8'd1);
            check({tag, ":scan_data"},  data_of(k), {4'd0, last_word[k]});
            start[k] = 1'($urandom_range(0, 1));
            ready[k] = 1'($urandom_range(0, 1));
            step();
        end
        check({tag, ":done_valid"}, {7'd0, valid_w[k]}, 8'd1);
        check({tag, ":done_data"},  data_of(k), {4'd0, inb});
        check({tag, ":done_addr"},  addr_of(k), 8'd0);
        check({tag, ":done_busy"},  {7'd0, busy_w[k]}, 8'd1);
        last_word[k] = inb;
        for (int h = 0; h < hold; h++) begin
            ready[k] = 1'b0;
            start[k] = 1'($urandom_range(0, 1));
            step();
            check({tag, ":hold_valid"}, {7'd0, valid_w[k]}, 8'd1);
            check({tag, ":hold_data"},  data_of(k), {4'd0, inb});
        end
        ready[k] = 1'b1;
        start[k] = 1'b0;
        step();
        check({tag, ":post_valid"}, {7'd0, valid_w[k]}, 8'd0);
        check({tag, ":post_busy"},  {7'd0, busy_w[k]}, {7'd0, AUTO});
        check({tag, ":post_addr"},  addr_of(k), 8'd0);
        check({tag, ":post_data"},  data_of(k), {4'd0, inb});
    endtask

    initial begin
        rst_n        = 1'b0;
        start        = 2'b00;
        ready        = 2'b11;
        in_bits[0]   = 4'b0000;
        in_bits[1]   = 4'b0000;
        last_word[0] = 4'd0;
        last_word[1] = 4'd0;

        @(negedge clk);
        check_quiet(0, "reset1");
        check_quiet(1, "reset3");
        rst_n = 1'b1;
        step();

        // Abort mid-scan at address 2
        in_bits[0] = 4'b1101;
        start[0]   = 1'b1;
        step();
        start[0] = 1'b0;
        check("abort:addr0", addr_of(0), 8'd0);
        step();
        step();
        check("abort:addr2", addr_of(0), 8'd2);
        rst_n = 1'b0;
        #1;
        check_quiet(0, "abort_rst");
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            check_quiet(0, "abort_after");
        end

        // SETTLE=3 instance
        run_scan(1, 3, 4'b0110, 0, 1'b1, "s3_a");
        run_scan(1, 3, 4'($urandom_range(0, 15)), 2, !AUTO, "s3_b");

        // SETTLE=1 instance: basic, backpressure, input change between scans, random
        run_scan(0, 1, 4'b1101, 0, 1'b1, "s1_basic");
        run_scan(0, 1, 4'b1101, 5, !AUTO, "s1_bp");
        run_scan(0, 1, 4'b1000, 0, !AUTO, "s1_change");
        for (int i = 0; i < 6; i++) begin
            run_scan(0, 1, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)), !AUTO, "s1_rand");
        end

        // Without auto-rescan the block must sit idle; with it the next scan simply proceeds
        if (!AUTO) begin
            for (int i = 0; i < 5; i++) begin
                step();
                check_quiet(0, "idle_tail");
            end
        end else begin
            run_scan(0, 1, 4'b0101, 0, 1'b0, "auto_tail");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
